// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: 4:1 round-robin or fixed-priority arbiter that
// registers the winning word into a one-deep valid/ready output stage.
module rr_mux_arbiter_4 #(
  parameter int WIDTH      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       i_req,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [3:0]       o_gnt,
  output logic [1:0]       o_sel,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, word;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       win, rr_idx;
  logic             rr_found;
  logic             cap;

  // A full stage can only take a new word if it drains this cycle.
  assign cap = (|i_req) & ((state_q == EMPTY) | i_ready) & ~rst;

  always_comb begin
    win      = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    if (FIXED_PRIO) begin
      for (int k = 3; k >= 0; k--) begin
        if (i_req[k]) win = 2'(k);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        rr_idx = last_q + 2'(k + 1);
        if (!rr_found && i_req[rr_idx]) begin
          win      = rr_idx;
          rr_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    word = i_a;
    unique case (win)
      2'd0: word = i_a;
      2'd1: word = i_b;
      2'd2: word = i_c;
      2'd3: word = i_d;
    endcase
  end

  always_comb begin
    o_gnt = 4'b0000;
    if (cap) o_gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cap) begin
      state_d = FULL;
    end else if (i_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    last_d = last_q;
    if (cap) begin
      data_d = word;
      sel_d  = win;
      last_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= 2'd0;
      last_q <= 2'd3;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    o_valid = (state_q == FULL);
    o_data  = data_q;
    o_sel   = sel_q;
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter and sequencer for the 8-bit, 4:1 bus mux datapath.
- Shares one downstream channel between four requesters (a, b, c, d). Each requester presents an 8-bit word plus a request.
- The block picks a winner, drives the mux select, registers the selected word into an output stage and hands it off downstream with a valid/ready handshake.
- Sits between the requester blocks and any single-consumer sink (e.g. a shared bus or a register file write port).

Parameters:
- WIDTH, 8, data width of each requester word and of o_data.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = fixed priority, a > b > c > d.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  4  request per requester; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
- i_a  in  WIDTH  requester a data.
- i_b  in  WIDTH  requester b data.
- i_c  in  WIDTH  requester c data.
- i_d  in  WIDTH  requester d data.
- o_gnt  out  4  one-hot, combinational; high in the cycle the winner's word is captured (acts as the requester's ack).
- o_sel  out  2  registered index of the most recent winner; drives the mux select.
- o_valid  out  1  output word valid.
- o_data  out  WIDTH  output word.
- i_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=1 at a rising edge):
  - o_valid=0, o_data=0, o_sel=2'b00.
  - Internal last-winner pointer = 3, so the first round-robin search starts at a.
  - o_gnt=0 while rst is high.
- States:
  - EMPTY (o_valid=0) and FULL (o_valid=1). The state equals o_valid.
- Capture condition:
  - cap = (|i_req) & (!o_valid | i_ready) & !rst.
- Winner selection, round-robin (FIXED_PRIO=0):
  - Search starts at index (last+1) mod 4 and wraps 3 -> 0.
  - The first index with i_req set wins.
- Winner selection, fixed priority (FIXED_PRIO=1):
  - The lowest set index wins. The pointer still updates but is ignored.
- On cap:
  - o_gnt = onehot(winner), in the same cycle.
  - Next edge: o_data <= word of winner, o_sel <= winner, last <= winner, o_valid <= 1.
- Latency: one cycle from the grant cycle to o_valid.
- No cap but i_ready=1 while FULL: o_valid <= 0 (FULL -> EMPTY). o_data and o_sel hold.
- FULL and i_ready=0:
  - All output registers hold.
  - o_gnt=0; no capture. Back-pressure stalls every requester.
- Simultaneous drain and refill (FULL, i_ready=1, |i_req): the new word is captured in the same cycle. o_valid stays 1, giving full throughput of one word per cycle.
- Single requester: it wins on every cap, including when it is the same as last.
- i_req=0: o_gnt=0 and the pointer holds.
- Requesters must hold their data stable while i_req is high and o_gnt is low. The arbiter samples data only in the grant cycle.
- A requester drops or changes its request freely after the grant cycle; there is no lock.
- Reset mid-transfer: the held word is discarded, o_valid=0 on the next edge, the pointer returns to 3, and there is no grant in the reset cycle.
- o_data and o_sel must never change while o_valid=1 and i_ready=0.

Test Plan:
- Reset: rst=1 for 2 cycles with i_req=4'hF -> o_valid=0, o_data=8'h00, o_sel=0, o_gnt=0.
- Round-robin fairness:
  - Setup: i_a..i_d = 8'h01..8'h04, i_req=4'hF held, i_ready=1.
  - Required: o_gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Required: o_data 01, 02, 03, 04, 01 on consecutive cycles, with o_valid continuously 1.
- Back-pressure:
  - Setup: i_req=4'b0110, i_ready=0 after the first capture.
  - Required: o_data=8'h02 and o_sel=1 held for 5 cycles, o_gnt=0.
  - Then i_ready=1 -> next capture is c (o_data=8'h03, o_sel=2).
- Wrap/skip:
  - Setup: last=c (2), i_req=4'b0011.
  - Required: winner a (pointer wraps past d); the next winner is b.
- Drain: single word from d, then i_req=0 with i_ready=1 -> o_valid goes 1 then 0, o_data stays 8'h04, o_sel stays 3.
- Fixed priority (FIXED_PRIO=1):
  - Setup: i_req=4'hF held, i_ready=1.
  - Required: o_gnt=0001 every cycle, o_data=8'h01.
  - Mid-stream rst pulse -> o_valid=0 for the next cycle, then resumes with a.
